// File: rtl/audio_pkg.sv
// Shared audio constants and the stereo sample bundle.
package audio_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int SLOT_WIDTH_DEF = 32;
  localparam int BCLK_DIV_DEF   = 32;

  // Samples are stored left-justified in a 32-bit container.
  localparam int SAMPLE_MAX = 32;

  typedef struct packed {
    logic [SAMPLE_MAX-1:0] left;
    logic [SAMPLE_MAX-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock divider: rise/fall event strobes and registered BCLK.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst_n,
  output logic rise,
  output logic fall,
  output logic bclk
);

  localparam int CW = $clog2(BCLK_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(BCLK_DIV/2 - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign rise = (div_cnt == RISE_AT);
  assign fall = (div_cnt == FALL_AT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= fall ? '0 : div_cnt + CW'(1);
      if (rise)
        bclk <= 1'b1;
      else if (fall)
        bclk <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_transceiver.sv
// Full-duplex I2S master with valid/ready tx and strobed rx ports.
// Define I2S_LOOPBACK_EN to feed the receiver from o_sdata.
module i2s_transceiver
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SLOT_WIDTH = SLOT_WIDTH_DEF,
  parameter int BCLK_DIV   = BCLK_DIV_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  input  logic                  i_sdata,
  input  logic [DATA_WIDTH-1:0] i_tx_left,
  input  logic [DATA_WIDTH-1:0] i_tx_right,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic                  o_tx_underrun,
  output logic [DATA_WIDTH-1:0] o_rx_left,
  output logic [DATA_WIDTH-1:0] o_rx_right,
  output logic                  o_rx_valid
);

  localparam int BW = $clog2(2*SLOT_WIDTH);
  localparam logic [BW-1:0] B_LAST  = BW'(2*SLOT_WIDTH - 1);
  localparam logic [BW-1:0] L_FIRST = BW'(1);
  localparam logic [BW-1:0] L_LAST  = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] R_SLOT  = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0] R_FIRST = BW'(SLOT_WIDTH + 1);
  localparam logic [BW-1:0] R_LAST  = BW'(SLOT_WIDTH + DATA_WIDTH);
  localparam int JUST = SAMPLE_MAX - DATA_WIDTH;

  logic                  rise;
  logic                  fall;
  logic                  load;
  logic                  rx_bit;
  logic [BW-1:0]         b;
  logic [BW-1:0]         b_next;
  logic                  nxt_left;
  logic                  nxt_right;
  logic                  cur_left;
  logic                  cur_right;
  stereo_sample_t        hold;
  logic [SAMPLE_MAX-1:0] tx_l;
  logic [SAMPLE_MAX-1:0] tx_r;
  logic [DATA_WIDTH-1:0] rx_l;
  logic [DATA_WIDTH-1:0] rx_r;

  i2s_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk (
    .clk  (i_clock),
    .rst_n(i_reset_n),
    .rise (rise),
    .fall (fall),
    .bclk (o_bclk)
  );

`ifdef I2S_LOOPBACK_EN
  logic unused_sdata;
  assign unused_sdata = i_sdata;
  assign rx_bit = o_sdata;
`else
  assign rx_bit = i_sdata;
`endif

  always_comb begin
    b_next = (b == B_LAST) ? '0 : b + BW'(1);
  end

  assign load      = fall && (b_next == '0);
  assign nxt_left  = (b_next >= L_FIRST) && (b_next <= L_LAST);
  assign nxt_right = (b_next >= R_FIRST) && (b_next <= R_LAST);
  assign cur_left  = (b >= L_FIRST) && (b <= L_LAST);
  assign cur_right = (b >= R_FIRST) && (b <= R_LAST);

  // Frame counter and transmit serialiser, all stepped on fall events.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      b             <= B_LAST;
      o_lrclk       <= 1'b1;
      o_sdata       <= 1'b0;
      tx_l          <= '0;
      tx_r          <= '0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_tx_underrun <= 1'b0;
      if (fall) begin
        b       <= b_next;
        o_lrclk <= (b_next >= R_SLOT);
        o_sdata <= 1'b0;
        if (b_next == '0) begin
          if (!o_tx_ready) begin
            tx_l <= hold.left;
            tx_r <= hold.right;
          end else begin
            tx_l          <= '0;
            tx_r          <= '0;
            o_tx_underrun <= 1'b1;
          end
        end else if (nxt_left) begin
          o_sdata <= tx_l[SAMPLE_MAX-1];
          tx_l    <= tx_l << 1;
        end else if (nxt_right) begin
          o_sdata <= tx_r[SAMPLE_MAX-1];
          tx_r    <= tx_r << 1;
        end
      end
    end
  end

  // Holding register: o_tx_ready low means a pair is waiting.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hold       <= '0;
      o_tx_ready <= 1'b1;
    end else if (load && !o_tx_ready) begin
      o_tx_ready <= 1'b1;
    end else if (i_tx_valid && o_tx_ready) begin
      hold.left  <= SAMPLE_MAX'(i_tx_left) << JUST;
      hold.right <= SAMPLE_MAX'(i_tx_right) << JUST;
      o_tx_ready <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_l       <= '0;
      rx_r       <= '0;
      o_rx_left  <= '0;
      o_rx_right <= '0;
      o_rx_valid <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      if (rise) begin
        if (cur_left)
          rx_l <= {rx_l[DATA_WIDTH-2:0], rx_bit};
        if (cur_right)
          rx_r <= {rx_r[DATA_WIDTH-2:0], rx_bit};
        // Right LSB completes the pair; publish it straight away.
        if (b == R_LAST) begin
          o_rx_left  <= rx_l;
          o_rx_right <= {rx_r[DATA_WIDTH-2:0], rx_bit};
          o_rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_transceiver.sv
// Directed bench for i2s_transceiver with default parameters.
module tb_i2s_transceiver;

  localparam int DW = 24;

  typedef struct {
    int   b;
    logic sdata;
    logic lrclk;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          i_sdata;
  logic [DW-1:0] tx_left;
  logic [DW-1:0] tx_right;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_underrun;
  logic [DW-1:0] rx_left;
  logic [DW-1:0] rx_right;
  logic          rx_valid;

  logic [DW-1:0] codec_l = 24'h123456;
  logic [DW-1:0] codec_r = 24'hABCDEF;

  int cyc;
  int checks = 0;
  int failures = 0;
  int und_cnt = 0;
  int rxv_cnt = 0;
  int ones_cnt = 0;

  vec_t v0[14];
  vec_t v3[9];

  i2s_transceiver dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .o_bclk       (bclk),
    .o_lrclk      (lrclk),
    .o_sdata      (sdata),
    .i_sdata      (i_sdata),
    .i_tx_left    (tx_left),
    .i_tx_right   (tx_right),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_tx_underrun(tx_underrun),
    .o_rx_left    (rx_left),
    .o_rx_right   (rx_right),
    .o_rx_valid   (rx_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cyc <= 0;
    else
      cyc <= cyc + 1;
  end

  function automatic int b_of(int c);
    if (c < 32)
      return 63;
    return (c / 32 - 1) % 64;
  endfunction

  // Codec model: I2S left-justified one bit after the LRCLK edge.
  always_comb begin
    i_sdata = 1'b0;
    if (b_of(cyc) >= 1 && b_of(cyc) <= 24)
      i_sdata = codec_l[24 - b_of(cyc)];
    else if (b_of(cyc) >= 33 && b_of(cyc) <= 56)
      i_sdata = codec_r[56 - b_of(cyc)];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic step_to(input int n);
    int guard = 0;
    while (cyc < n) begin
      @(negedge clk);
      if (tx_underrun) und_cnt++;
      if (rx_valid) rxv_cnt++;
      if (sdata) ones_cnt++;
      guard++;
      if (guard > 20000) begin
        failures++;
        $display("FAIL step_to actual=%0d required=%0d",
                 cyc, n);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "cycle budget expired");
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bclk"}, 32'(bclk), 0);
    chk({tag, "_lrclk"}, 32'(lrclk), 1);
    chk({tag, "_sdata"}, 32'(sdata), 0);
    chk({tag, "_ready"}, 32'(tx_ready), 1);
    chk({tag, "_underrun"}, 32'(tx_underrun), 0);
    chk({tag, "_rx_left"}, 32'(rx_left), 0);
    chk({tag, "_rx_right"}, 32'(rx_right), 0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
  endtask

  initial begin
    // Frame 0 carries left=800001, right=7FFFFE.
    v0 = '{
      '{0,  1'b0, 1'b0}, '{1,  1'b1, 1'b0},
      '{2,  1'b0, 1'b0}, '{23, 1'b0, 1'b0},
      '{24, 1'b1, 1'b0}, '{25, 1'b0, 1'b0},
      '{31, 1'b0, 1'b0}, '{32, 1'b0, 1'b1},
      '{33, 1'b0, 1'b1}, '{34, 1'b1, 1'b1},
      '{55, 1'b1, 1'b1}, '{56, 1'b0, 1'b1},
      '{57, 1'b0, 1'b1}, '{63, 1'b0, 1'b1}
    };
    // Frame 3 carries left=C00003, right=000001.
    v3 = '{
      '{1,  1'b1, 1'b0}, '{2,  1'b1, 1'b0},
      '{3,  1'b0, 1'b0}, '{23, 1'b1, 1'b0},
      '{24, 1'b1, 1'b0}, '{25, 1'b0, 1'b0},
      '{32, 1'b0, 1'b1}, '{33, 1'b0, 1'b1},
      '{34, 1'b0, 1'b1}
    };

    tx_valid = 1'b0;
    tx_left  = '0;
    tx_right = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");

    rst_n    = 1'b1;
    tx_left  = 24'h800001;
    tx_right = 24'h7FFFFE;
    tx_valid = 1'b1;
    step_to(1);
    tx_valid = 1'b0;
    chk("ready_drop", 32'(tx_ready), 0);

    step_to(15);
    chk("bclk_c15", 32'(bclk), 0);
    step_to(16);
    chk("bclk_c16", 32'(bclk), 1);
    step_to(31);
    chk("bclk_c31", 32'(bclk), 1);
    chk("lrclk_c31", 32'(lrclk), 1);
    step_to(32);
    chk("bclk_c32", 32'(bclk), 0);
    chk("lrclk_c32", 32'(lrclk), 0);
    chk("ready_reload", 32'(tx_ready), 1);
    chk("no_underrun_f0", 32'(tx_underrun), 0);

    foreach (v0[i]) begin
      step_to(32 * (v0[i].b + 1) + 16);
      chk($sformatf("f0_sdata_b%0d", v0[i].b),
          32'(sdata), 32'(v0[i].sdata));
      chk($sformatf("f0_lrclk_b%0d", v0[i].b),
          32'(lrclk), 32'(v0[i].lrclk));
    end
    chk("f0_rx_pulses", rxv_cnt, 1);
    chk("f0_underruns", und_cnt, 0);

    step_to(2079);
    chk("lrclk_c2079", 32'(lrclk), 1);
    step_to(2080);
    chk("lrclk_c2080", 32'(lrclk), 0);
    chk("underrun_f1", 32'(tx_underrun), 1);
    step_to(2081);
    chk("underrun_f1_end", 32'(tx_underrun), 0);

    und_cnt  = 0;
    rxv_cnt  = 0;
    ones_cnt = 0;
    step_to(3887);
    chk("rx_valid_pre", 32'(rx_valid), 0);
    step_to(3888);
    chk("rx_valid", 32'(rx_valid), 1);
    chk("rx_left", 32'(rx_left), 32'h123456);
    chk("rx_right", 32'(rx_right), 32'hABCDEF);
    step_to(3889);
    chk("rx_valid_post", 32'(rx_valid), 0);
    step_to(4127);
    chk("f1_silent", ones_cnt, 0);
    chk("f1_extra_underrun", und_cnt, 0);
    chk("f1_rx_pulses", rxv_cnt, 1);

    // Handshake lands on the same edge as an empty load.
    tx_left  = 24'hC00003;
    tx_right = 24'h000001;
    tx_valid = 1'b1;
    step_to(4128);
    tx_valid = 1'b0;
    chk("collide_underrun", 32'(tx_underrun), 1);
    chk("collide_ready", 32'(tx_ready), 0);
    ones_cnt = 0;
    step_to(6175);
    chk("f2_silent", ones_cnt, 0);
    step_to(6176);
    chk("f3_ready", 32'(tx_ready), 1);
    chk("f3_underrun", 32'(tx_underrun), 0);

    foreach (v3[i]) begin
      step_to(6176 + 32 * v3[i].b + 16);
      chk($sformatf("f3_sdata_b%0d", v3[i].b),
          32'(sdata), 32'(v3[i].sdata));
      chk($sformatf("f3_lrclk_b%0d", v3[i].b),
          32'(lrclk), 32'(v3[i].lrclk));
    end

    // Abort mid right slot while BCLK is high.
    step_to(6176 + 32 * 40 + 20);
    chk("pre_abort_bclk", 32'(bclk), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    rxv_cnt = 0;
    step_to(1839);
    chk("post_abort_quiet", rxv_cnt, 0);
    step_to(1840);
    chk("post_abort_valid", 32'(rx_valid), 1);
    chk("post_abort_left", 32'(rx_left), 32'h123456);
    chk("post_abort_right", 32'(rx_right), 32'hABCDEF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
